// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, result type and round-robin helper for the CDB arbiter
// Provides ROB_Entry_Width/Data_Width defaults (overridable by an earlier defines.v),
// CDB_Src_Num and CDB_Fifo_Depth, the packed result type and the rr successor function.
`ifndef ROB_Entry_Width
`define ROB_Entry_Width 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef CDB_Src_Num
`define CDB_Src_Num 3
`endif
`ifndef CDB_Fifo_Depth
`define CDB_Fifo_Depth 2
`endif
package cdb_arbiter_pkg;
  localparam int ENTRY_W = `ROB_Entry_Width;
  localparam int DATA_W = `Data_Width;
  localparam int SRC_NUM = `CDB_Src_Num;
  localparam int FIFO_DEPTH = `CDB_Fifo_Depth;
  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [DATA_W-1:0] value;
  } cdb_item_t;
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return s == 2'd2 ? 2'd0 : s + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: 2-entry per-source result FIFO feeding the CDB arbiter
// Ports: clk, rst (async, active-high), flush (empties), push/din (guarded by ready),
// pop (guarded by nonempty), head (oldest result), ready (count < 2), nonempty.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  cdb_item_t din,
  output cdb_item_t head,
  output logic      ready,
  output logic      nonempty
);
  cdb_item_t mem [FIFO_DEPTH];
  logic rd, wr, do_push, do_pop;
  logic [1:0] count;
  assign ready = ~count[1];
  assign nonempty = |count;
  assign head = mem[rd];
  assign do_push = push & ready & ~flush;
  assign do_pop = pop & nonempty & ~flush;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // single-bit pointers wrap modulo 2 by themselves
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wr <= ~wr;
      if (do_pop) rd <= ~rd;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter broadcasting one buffered result per cycle on the CDB
// Ports: clk, rst (async, active-high); per source i in 0..2: si_valid/si_entry/si_value in,
// si_ready out; flush squashes all buffered results; cdb_write/cdb_entry/cdb_value registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s0_valid,
  input  logic [`ROB_Entry_Width-1:0] s0_entry,
  input  logic [`Data_Width-1:0]      s0_value,
  output logic                        s0_ready,
  input  logic                        s1_valid,
  input  logic [`ROB_Entry_Width-1:0] s1_entry,
  input  logic [`Data_Width-1:0]      s1_value,
  output logic                        s1_ready,
  input  logic                        s2_valid,
  input  logic [`ROB_Entry_Width-1:0] s2_entry,
  input  logic [`Data_Width-1:0]      s2_value,
  output logic                        s2_ready,
  input  logic                        flush,
  output logic                        cdb_write,
  output logic [`ROB_Entry_Width-1:0] cdb_entry,
  output logic [`Data_Width-1:0]      cdb_value
);
  logic [SRC_NUM-1:0] valid, ready, nonempty;
  cdb_item_t din [SRC_NUM];
  cdb_item_t head [SRC_NUM];
  logic [1:0] rr, p1, p2, gsel;
  logic any;
  assign valid = {s2_valid, s1_valid, s0_valid};
  assign {s2_ready, s1_ready, s0_ready} = ready;
  assign din[0] = '{entry: s0_entry, value: s0_value};
  assign din[1] = '{entry: s1_entry, value: s1_value};
  assign din[2] = '{entry: s2_entry, value: s2_value};
  assign p1 = next_src(rr);
  assign p2 = next_src(p1);
  assign any = |nonempty;
  // first non-empty source scanning from rr; p2 is the fallback when only it can be requesting
  assign gsel = nonempty[rr] ? rr : nonempty[p1] ? p1 : p2;
  generate
    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
      cdb_src_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (valid[i]),
        .pop      (any && gsel == 2'(i)),
        .din      (din[i]),
        .head     (head[i]),
        .ready    (ready[i]),
        .nonempty (nonempty[i])
      );
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= 2'd0;
      cdb_write <= 1'b0;
      cdb_entry <= '0;
      cdb_value <= '0;
    end else if (flush) begin
      cdb_write <= 1'b0;
    end else begin
      cdb_write <= any;
      if (any) begin
        cdb_entry <= head[gsel].entry;
        cdb_value <= head[gsel].value;
        rr <= next_src(gsel);
      end
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have, for each i in 0..2, port si_valid, input, 1 bit: source i offers a result.
REQ-005 SHALL have, for each i, port si_entry, input, `ROB_Entry_Width bits: ROB tag of the result.
REQ-006 SHALL have, for each i, port si_value, input, `Data_Width bits: result data.
REQ-007 SHALL have, for each i, port si_ready, output, 1 bit: source i may present a result.
REQ-008 SHALL have port flush, input, 1 bit: misprediction squash, driven by the ROB pc_modify.
REQ-009 SHALL have port cdb_write, output, 1 bit: broadcast valid; reset value 0.
REQ-010 SHALL have port cdb_entry, output, `ROB_Entry_Width bits: broadcast tag; reset value 0.
REQ-011 SHALL have port cdb_value, output, `Data_Width bits: broadcast data; reset value 0.

Function
REQ-012 SHALL accept a result from source i at a rising edge when si_valid and si_ready are both 1; the result is pushed into that source's 2-entry FIFO.
REQ-013 SHALL drive si_ready = 1 while FIFO i holds fewer than 2 results; si_ready depends on registered count only, not on same-cycle pop.
REQ-014 SHALL consider, each cycle, the heads of all non-empty FIFOs as requesters.
REQ-015 SHALL grant exactly one requester per cycle, round-robin: the pointer rr (0..2) names the highest-priority source, with priority falling as rr, rr+1, rr+2 mod 3.
REQ-016 SHALL set rr to (g+1) mod 3 after granting source g; rr is unchanged when there is no grant.
REQ-017 SHALL, on the edge after a grant, pop the winning head, set cdb_write=1, and load cdb_entry/cdb_value from it.
REQ-018 SHALL set cdb_write=0 on any edge with no grant; cdb_entry/cdb_value hold their last values.
REQ-019 SHALL make a result accepted at edge k first visible on the CDB after edge k+1 (1-cycle minimum latency; no bypass).
REQ-020 SHALL keep each source's results in order; there is no reordering within a source.
REQ-021 SHALL handle push and pop on the same FIFO in one edge with count unchanged and correct order.
REQ-022 SHALL, on an edge with flush=1, empty all FIFOs, force cdb_write=0, and discard any inputs presented at that edge; rr is unchanged.
REQ-023 SHALL wrap FIFO read/write pointers modulo 2; the count range is 0..2.
REQ-024 SHALL NOT emit more than one broadcast per cycle or duplicate a result.

Reset
REQ-025 SHALL, while rst=1 and regardless of clk, clear all FIFOs and set rr=0, cdb_write=0, cdb_entry=0, cdb_value=0.
REQ-026 SHALL drive every si_ready to 1 one cycle after rst deasserts.
REQ-027 SHALL lose any in-flight result when rst asserts mid-operation, with no broadcast.

Structure
REQ-028 SHALL take `ROB_Entry_Width and `Data_Width from defines.v, and SHALL add `CDB_Src_Num (3) and `CDB_Fifo_Depth (2) there.
REQ-029 SHALL instantiate one sub-module cdb_src_fifo (2-entry, push/pop/count/head, async reset) per source; arbitration and output registers live in cdb_arbiter.

Verification
REQ-030 SHALL test single source: s0 gives entry 3, value 0x0000_00AA at edge 1 -> cdb_write=1, entry 3, value 0xAA after edge 2, then 0 after edge 3.
REQ-031 SHALL test contention: s0/s1/s2 give tags 1/2/3 at the same edge with rr=0 -> broadcasts 1, 2, 3 on consecutive cycles, ending with rr=0.
REQ-032 SHALL test fairness: s0 and s1 both continuously valid -> grants alternate 0, 1, 0, 1; no source waits more than 2 cycles.
REQ-033 SHALL test backpressure: s2 pushes 2 results while s0/s1 always win -> s2_ready=0 until the first s2 result is broadcast, then 1 the next cycle.
REQ-034 SHALL test flush: FIFOs holding 4 results, flush=1 for one edge -> cdb_write=0 next cycle, all si_ready=1, and none of the 4 results is ever broadcast.
REQ-035 SHALL test async reset: rst pulses between clock edges while cdb_write=1 -> cdb_write=0 at once, before the next edge.
